pullit: RTL and testbench
=========================

# pullit

Read-side parser for the drift-chamber readout byte stream. Pops bytes from the readout FIFO and re-frames them into trigger records (trigger number plus 36-bit trigger time) and cycle records (cycle number). Presents each record on a valid/ready output, and counts framing errors. Sits between the readout FIFO and the downstream event builder and uses the same block format as the FIFO writer.

## Interface
- `TRIG_HDR`, default 8'hFF: trigger-record header byte.
- `CYC_HDR`, default 8'hBF: cycle-record header byte.
- `ERRW`, default 16: error counter width.
- `TIMEOUT`, default 1024: idle clocks allowed inside a record. Used only with `PULLIT_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  8  FIFO head byte, first-word-fall-through; valid while `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO has no data.
- `fifo_rd`  out  1  pop strobe; the head byte is consumed at the clock edge where it is 1.
- `out_ready`  in  1  downstream accepts a record.
- `trig_valid`  out  1  trigger record held on the outputs.
- `cycle_valid`  out  1  cycle record held on the outputs.
- `trignum`  out  18  trigger number.
- `timenum`  out  36  trigger time.
- `cyclenum`  out  18  cycle number.
- `err_pulse`  out  1  one-clock pulse per framing error.
- `err_count`  out  ERRW  saturating count of framing errors.

## Operation
- Byte classes:
  - Header: bit7=1.
  - Data: bits[7:6]=00, with the payload in bits[5:0].
  - Illegal: bits[7:6]=01.
- Field order, least significant 6 bits first:
  - Trigger record: header, 3 bytes of `trignum`, then 6 bytes of `timenum`.
  - Cycle record: header, 3 bytes of `cyclenum`.
- `fifo_rd` = !`fifo_empty` && state≠HOLD. This is combinational; at most one byte per clock.
- State IDLE:
  - `TRIG_HDR` → TRIG with idx=0.
  - `CYC_HDR` → CYC with idx=0.
  - Any other header, a data byte or an illegal byte → error; the byte is dropped and the state stays IDLE.
- State TRIG:
  - A data byte at idx k<3 loads trignum[6k+5:6k].
  - A data byte at idx 3 ≤ k ≤ 8 loads timenum[6(k-3)+5:6(k-3)].
  - At idx 8 → HOLD with trig_valid=1.
- State CYC:
  - A data byte at idx k loads cyclenum[6k+5:6k].
  - At idx 2 → HOLD with cycle_valid=1.
- Inside TRIG or CYC:
  - `TRIG_HDR`/`CYC_HDR` → error; the partial record is discarded and the byte starts a new record (resync, byte consumed).
  - Another header value or an illegal byte → error, go to IDLE.
- State HOLD: outputs are frozen. If `out_ready`=1 at the edge, valid drops and the state goes to IDLE.
- trig_valid and cycle_valid are never high together.
- Field registers are overwritten only by the next record. Their values outside valid are don't-care.
- err_count saturates at all-ones. err_pulse still fires after saturation.

## Timing
- Reset: state IDLE, idx 0, and every output register 0 (valids, `trignum`, `timenum`, `cyclenum`, `err_pulse`, `err_count`). `fifo_rd` is 0 while `reset` is high.
- Latency: the last record byte is popped at edge N; valid is high from edge N to the handshake edge.
- After a handshake at edge M, `fifo_rd` can be 1 again in the cycle following M.
- Minimum spacing: 11 clocks per trigger record and 5 per cycle record.
- `err_pulse` is registered and high for the cycle after the offending byte's pop edge.
- Reset asserted mid-record drops the partial record and causes no error count.
- `fifo_empty` gaps inside a record are legal and stall the parser with no state change.

## Configuration
- `PULLIT_TIMEOUT_EN` defined:
  - In TRIG/CYC, a counter clears on every pop and increments while `fifo_empty`=1.
  - On reaching `TIMEOUT`: error, discard the partial record, go to IDLE.
- Not defined: no counter is built, and the parser waits indefinitely inside a record.

## Structure
- Package `pullit_pkg`:
  - Header constants.
  - Field width constants: 18, 36 and 6 bits per byte.
  - Record byte counts: 9 and 3.
  - State enum: IDLE, TRIG, CYC, HOLD.
- Optional sub-module `pullit_timeout`: a loadable idle counter with `clear`, `run` and `expired` ports, instantiated only under `PULLIT_TIMEOUT_EN`.

## Test plan
- Trigger record: feed FF,05,0D,12,01,01,00,00,00,00 → trig_valid with trignum=0x12345 and timenum=0x41. Hold `out_ready`=0 for 5 clocks: no pops and the outputs stay stable.
- Cycle record: feed BF,3F,3F,3F → cycle_valid with cyclenum=0x3FFFF after the 4th pop; err_count=0.
- Resync: feed FF,05,0D followed by a complete cycle record → err_count=1, then cycle_valid with correct data and no trig_valid.
- Garbage in IDLE: feed 0x15, 0x45, 0xC0 → 3 err_pulses, err_count=3, no valids. The next valid record parses correctly.
- FIFO gaps: insert 7-clock empty gaps between every byte of a trigger record → correct record and no error (macro undefined). With the macro defined and `TIMEOUT`=4 → err_count=1 and no valid.
- Reset: assert reset after 5 trigger bytes → all outputs 0. A new full record afterwards parses with err_count=0.

Source files
------------

// File: rtl/pullit_pkg.sv
// Shared constants, state encoding and byte classification for the pullit parser.
package pullit_pkg;

    localparam logic [7:0] DEF_TRIG_HDR = 8'hFF;
    localparam logic [7:0] DEF_CYC_HDR  = 8'hBF;

    localparam int unsigned TRIG_W = 18;
    localparam int unsigned TIME_W = 36;
    localparam int unsigned BYTE_W = 6;

    localparam int unsigned TRIG_BYTES = 9;
    localparam int unsigned CYC_BYTES  = 3;

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        CYC,
        HOLD
    } state_t;

    function automatic logic is_data(input logic [7:0] b);
        return b[7:6] == 2'b00;
    endfunction

endpackage

// File: rtl/pullit_timeout.sv
// Idle-clock counter used to abandon a stalled record; only present when PULLIT_TIMEOUT_EN is defined.
`ifdef PULLIT_TIMEOUT_EN
module pullit_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the LIMIT-th consecutive idle clock.
    assign expired = run && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/pullit.sv
// pullit: re-frames the readout FIFO byte stream into trigger and cycle records.
// Defining PULLIT_TIMEOUT_EN adds an idle timeout inside a partially received record.
module pullit
    import pullit_pkg::*;
#(
    parameter logic [7:0]  TRIG_HDR = DEF_TRIG_HDR,
    parameter logic [7:0]  CYC_HDR  = DEF_CYC_HDR,
    parameter int unsigned ERRW     = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic              out_ready,
    output logic              trig_valid,
    output logic              cycle_valid,
    output logic [TRIG_W-1:0] trignum,
    output logic [TIME_W-1:0] timenum,
    output logic [TRIG_W-1:0] cyclenum,
    output logic              err_pulse,
    output logic [ERRW-1:0]   err_count
);

    localparam logic [3:0] TRIG_LAST  = 4'(TRIG_BYTES - 1);
    localparam logic [3:0] CYC_LAST   = 4'(CYC_BYTES - 1);
    localparam logic [3:0] TIME_START = 4'(TRIG_W / BYTE_W);

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic        err;
    logic        load_trig, load_time, load_cyc;
    logic        in_rec;
    logic        tmo_expired;
    logic [5:0]  payload;

    assign fifo_rd = !reset && !fifo_empty && (state != HOLD);
    assign in_rec  = (state == TRIG) || (state == CYC);
    assign payload = fifo_data[5:0];

`ifdef PULLIT_TIMEOUT_EN
    pullit_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (reset),
        .clear  (fifo_rd || !in_rec),
        .run    (fifo_empty && in_rec),
        .expired(tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_expired    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err       = 1'b0;
        load_trig = 1'b0;
        load_time = 1'b0;
        load_cyc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_rd) begin
                    idx_nxt = '0;
                    if (fifo_data == TRIG_HDR)      state_nxt = TRIG;
                    else if (fifo_data == CYC_HDR)  state_nxt = CYC;
                    else                            err = 1'b1;
                end
            end
            TRIG, CYC: begin
                if (fifo_rd) begin
                    idx_nxt = '0;
                    if (fifo_data == TRIG_HDR) begin
                        err       = 1'b1;
                        state_nxt = TRIG;
                    end else if (fifo_data == CYC_HDR) begin
                        err       = 1'b1;
                        state_nxt = CYC;
                    end else if (is_data(fifo_data)) begin
                        if (state == TRIG) begin
                            load_trig = (idx < TIME_START);
                            load_time = !load_trig;
                            if (idx == TRIG_LAST) state_nxt = HOLD;
                            else                  idx_nxt   = idx + 1'b1;
                        end else begin
                            load_cyc = 1'b1;
                            if (idx == CYC_LAST) state_nxt = HOLD;
                            else                 idx_nxt   = idx + 1'b1;
                        end
                    end else begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_expired) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            trig_valid  <= 1'b0;
            cycle_valid <= 1'b0;
            trignum     <= '0;
            timenum     <= '0;
            cyclenum    <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            err_pulse   <= err;
            trig_valid  <= (state_nxt == HOLD) && ((state == HOLD) ? trig_valid  : (state == TRIG));
            cycle_valid <= (state_nxt == HOLD) && ((state == HOLD) ? cycle_valid : (state == CYC));
            if (err && (err_count != '1)) err_count <= err_count + 1'b1;
            // Fields shift in from the top, so after a full record the first byte sits in the LSBs.
            if (load_trig) trignum  <= {payload, trignum[TRIG_W-1:BYTE_W]};
            if (load_time) timenum  <= {payload, timenum[TIME_W-1:BYTE_W]};
            if (load_cyc)  cyclenum <= {payload, cyclenum[TRIG_W-1:BYTE_W]};
        end
    end

endmodule

// File: tb/tb_pullit.sv
// Self-checking bench for pullit: directed scenarios plus a randomized record/garbage stream.
module tb_pullit;

    localparam int unsigned ERRW    = 4;
    localparam int          ERR_MAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        out_ready;
    logic        trig_valid;
    logic        cycle_valid;
    logic [17:0] trignum;
    logic [35:0] timenum;
    logic [17:0] cyclenum;
    logic        err_pulse;
    logic [ERRW-1:0] err_count;

    pullit #(
        .TRIG_HDR(8'hFF),
        .CYC_HDR (8'hBF),
        .ERRW    (ERRW),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .out_ready  (out_ready),
        .trig_valid (trig_valid),
        .cycle_valid(cycle_valid),
        .trignum    (trignum),
        .timenum    (timenum),
        .cyclenum   (cyclenum),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // 2'b10 trigger, 2'b01 cycle
        logic [35:0] a;
        logic [35:0] b;
    } rec_t;

    logic [7:0] stim_q[$];
    rec_t       exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_err  = 0;
    int pulses   = 0;
    int gap_pct  = 0;
    int gap_fixed = 0;
    int gap_left = 0;
    int rdy_pct  = 100;
    int hold_min = 0;
    int hold_cnt = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] rand_data();
        return {2'b00, 6'($urandom())};
    endfunction

    function automatic logic [7:0] bad_byte(input bit allow_data);
        logic [7:0] b;
        int unsigned sel;
        sel = allow_data ? $urandom_range(0, 2) : $urandom_range(1, 2);
        case (sel)
            0:       b = rand_data();
            1:       b = {2'b01, 6'($urandom())};
            default: begin
                b = {1'b1, 7'($urandom())};
                if (b == 8'hFF || b == 8'hBF) b = 8'hC0;
            end
        endcase
        return b;
    endfunction

    task automatic add_trig(input logic [17:0] t, input logic [35:0] tm);
        rec_t r;
        logic [17:0] v;
        logic [35:0] w;
        v = t;
        w = tm;
        stim_q.push_back(8'hFF);
        repeat (3) begin stim_q.push_back({2'b00, v[5:0]}); v = v >> 6; end
        repeat (6) begin stim_q.push_back({2'b00, w[5:0]}); w = w >> 6; end
        r.kind = 2'b10;
        r.a    = 36'(t);
        r.b    = tm;
        exp_q.push_back(r);
    endtask

    task automatic add_cyc(input logic [17:0] c);
        rec_t r;
        logic [17:0] v;
        v = c;
        stim_q.push_back(8'hBF);
        repeat (3) begin stim_q.push_back({2'b00, v[5:0]}); v = v >> 6; end
        r.kind = 2'b01;
        r.a    = 36'(c);
        r.b    = '0;
        exp_q.push_back(r);
    endtask

    task automatic add_random_record();
        if ($urandom_range(0, 1) == 1) add_trig(18'($urandom()), 36'({$urandom(), $urandom()}));
        else                           add_cyc(18'($urandom()));
    endtask

    // Called just after a falling edge: check outputs, then drive inputs for the next rising edge.
    task automatic step(input bit feed);
        logic valid;
        rec_t r;
        valid = trig_valid || cycle_valid;
        if (err_pulse) pulses++;
        hold_cnt  = valid ? hold_cnt + 1 : 0;
        out_ready = (hold_cnt > hold_min) && ($urandom_range(0, 99) < rdy_pct);
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rec", 36'({trig_valid, cycle_valid}), 36'(0));
            end else begin
                r = exp_q[0];
                check("rec_kind", 36'({trig_valid, cycle_valid}), 36'(r.kind));
                if (r.kind == 2'b10) begin
                    check("trignum", 36'(trignum), r.a);
                    check("timenum", timenum, r.b);
                end else begin
                    check("cyclenum", 36'(cyclenum), r.a);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (feed && stim_q.size() > 0 && gap_left == 0 && $urandom_range(0, 99) >= gap_pct) begin
            fifo_empty = 1'b0;
            fifo_data  = stim_q[0];
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = 8'($urandom());
            if (gap_left > 0) gap_left--;
        end
        #1;
        check("fifo_rd", 36'(fifo_rd), 36'(!fifo_empty && !valid));
        if (fifo_rd) begin
            void'(stim_q.pop_front());
            gap_left = gap_fixed;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            step(1'b0);
        end
    endtask

    task automatic run_stream(input int max_cycles);
        int cyc;
        cyc = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            step(1'b1);
        end
        check("stream_drained", 36'(stim_q.size() + exp_q.size()), 36'(0));
        idle(3);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_pulses"}, 36'(pulses), 36'(exp_err));
        check({tag, "_count"}, 36'(err_count), 36'((exp_err > ERR_MAX) ? ERR_MAX : exp_err));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 8'hFF;
        out_ready  = 1'b0;
        @(negedge clk);
        check("rst_trig_valid", 36'(trig_valid), 36'(0));
        check("rst_cycle_valid", 36'(cycle_valid), 36'(0));
        check("rst_trignum", 36'(trignum), 36'(0));
        check("rst_timenum", timenum, 36'(0));
        check("rst_cyclenum", 36'(cyclenum), 36'(0));
        check("rst_err_pulse", 36'(err_pulse), 36'(0));
        check("rst_err_count", 36'(err_count), 36'(0));
        check("rst_fifo_rd", 36'(fifo_rd), 36'(0));
        stim_q.delete();
        exp_q.delete();
        exp_err  = 0;
        pulses   = 0;
        gap_left = 0;
        hold_cnt = 0;
        @(negedge clk);
        reset      = 1'b0;
        fifo_empty = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_data  = '0;
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        do_reset();

        // Example trigger record, held for 5 clocks before acceptance.
        hold_min = 5;
        foreach (stim_q[i]) stim_q.delete(i);
        stim_q = '{8'hFF, 8'h05, 8'h0D, 8'h12, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back('{kind: 2'b10, a: 36'h12345, b: 36'h41});
        run_stream(200);
        check_errs("trig_ex");
        hold_min = 0;

        add_cyc(18'h3FFFF);
        run_stream(200);
        check_errs("cyc_max");

        // Truncated trigger record resynchronised by a cycle header.
        stim_q = '{8'hFF, 8'h05, 8'h0D};
        exp_err++;
        add_cyc(18'h03081);
        run_stream(200);
        check_errs("resync");

        do_reset();
        stim_q = '{8'h15, 8'h45, 8'hC0};
        exp_err += 3;
        add_trig(18'h2A5A5, 36'h9_8765_4321);
        run_stream(200);
        check_errs("garbage");

        gap_fixed = 7;
`ifdef PULLIT_TIMEOUT_EN
        stim_q.push_back(8'hFF);
        exp_err++;
        run_stream(200);
        idle(10);
`else
        add_trig(18'h1F0F0, 36'hA_5A5A_5A5A);
        run_stream(400);
`endif
        check_errs("gaps");
        gap_fixed = 0;

        stim_q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(200);
        do_reset();
        add_trig(18'h0_0FFF, 36'hF_FFFF_FFFF);
        run_stream(200);
        check_errs("after_reset");

        // Random mix of records, idle garbage and truncated records; errors exceed the counter range.
        gap_pct = 30;
        rdy_pct = 50;
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0, 1: add_random_record();
                2: begin
                    stim_q.push_back(bad_byte(1'b1));
                    exp_err++;
                end
                default: begin
                    int unsigned k;
                    bit          is_trig;
                    is_trig = ($urandom_range(0, 1) == 1);
                    stim_q.push_back(is_trig ? 8'hFF : 8'hBF);
                    k = is_trig ? $urandom_range(0, 8) : $urandom_range(0, 2);
                    repeat (k) stim_q.push_back(rand_data());
                    exp_err++;
                    if ($urandom_range(0, 1) == 1) stim_q.push_back(bad_byte(1'b0));
                    else                           add_random_record();
                end
            endcase
        end
        run_stream(20000);
        check_errs("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
